// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus target state encoding, widths and device IDs
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } bus_tgt_state_t;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 16;

  localparam int DEV_RAM = 0;
  localparam int DEV_ROM = 1;
  localparam int DEV_VGA = 2;
  localparam int DEV_PS2 = 3;
  localparam int DEV_ACP = 4;

  localparam int BUS_WINDOW_WORDS = 16;

endpackage

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - loadable 4-bit down-counter for wait-state insertion
module bus_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  // Saturates at zero so a stray dec can never wrap into a long wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/bus_reg_target.sv
// rtl/bus_reg_target.sv - wait-stated responder driving a 16-word peripheral register port
module bus_reg_target
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int NUM_REGS    = BUS_WINDOW_WORDS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        req,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic                        we,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        ack,
  output logic                        err,
  output logic                        busy,
  output logic [$clog2(NUM_REGS)-1:0] periph_addr,
  output logic                        periph_wr,
  output logic                        periph_rd,
  output logic [DATA_WIDTH-1:0]       periph_wdata,
  input  logic [DATA_WIDTH-1:0]       periph_rdata
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_tgt_state_t state;
  logic           we_q;
  logic           cnt_load;
  logic           cnt_dec;
  logic           cnt_zero;

  assign cnt_load = (state == ST_IDLE) && req && en;
  assign cnt_dec  = (state == ST_WAIT);

  bus_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Outputs are registered on the transition into the state that owns them,
  // so strobes and ack line up exactly with ACCESS and ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      we_q         <= 1'b0;
      ack          <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      periph_wr    <= 1'b0;
      periph_rd    <= 1'b0;
      rdata        <= '0;
      periph_addr  <= '0;
      periph_wdata <= '0;
    end else begin
      ack       <= 1'b0;
      err       <= 1'b0;
      periph_wr <= 1'b0;
      periph_rd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && en) begin
            we_q         <= we;
            periph_addr  <= addr[IDX_W-1:0];
            periph_wdata <= wdata;
            busy         <= 1'b1;
            if (addr >= ADDR_WIDTH'(NUM_REGS)) begin
              state <= ST_ACK;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state     <= ST_ACCESS;
              periph_wr <= we;
              periph_rd <= !we;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            state     <= ST_ACCESS;
            periph_wr <= we_q;
            periph_rd <= !we_q;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            rdata <= periph_rdata;
          end
          state <= ST_ACK;
          ack   <= 1'b1;
        end
        ST_ACK: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_reg_target.sv
// tb/tb_bus_reg_target.sv - directed self-checking bench for bus_reg_target
module tb_bus_reg_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [15:0] wdata;

  logic [15:0] rdata, periph_wdata, periph_rdata;
  logic        ack, err, busy, periph_wr, periph_rd;
  logic [3:0]  periph_addr;

  logic [15:0] rdata_z, periph_wdata_z, periph_rdata_z;
  logic        ack_z, err_z, busy_z, periph_wr_z, periph_rd_z;
  logic [3:0]  periph_addr_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] reg_model(input logic [3:0] a);
    case (a)
      4'h1:    reg_model = 16'hA5A5;
      4'h3:    reg_model = 16'h1234;
      4'hF:    reg_model = 16'hC0DE;
      default: reg_model = 16'h0F00 | {12'h0, a};
    endcase
  endfunction

  assign periph_rdata   = reg_model(periph_addr);
  assign periph_rdata_z = reg_model(periph_addr_z);

  bus_reg_target #(.WAIT_CYCLES(2)) dut (
    .clk (clk), .rst (rst), .en (en), .req (req), .addr (addr), .we (we), .wdata (wdata),
    .rdata (rdata), .ack (ack), .err (err), .busy (busy),
    .periph_addr (periph_addr), .periph_wr (periph_wr), .periph_rd (periph_rd),
    .periph_wdata (periph_wdata), .periph_rdata (periph_rdata)
  );

  bus_reg_target #(.WAIT_CYCLES(0)) dut_z (
    .clk (clk), .rst (rst), .en (en), .req (req), .addr (addr), .we (we), .wdata (wdata),
    .rdata (rdata_z), .ack (ack_z), .err (err_z), .busy (busy_z),
    .periph_addr (periph_addr_z), .periph_wr (periph_wr_z), .periph_rd (periph_rd_z),
    .periph_wdata (periph_wdata_z), .periph_rdata (periph_rdata_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Single access on the WAIT_CYCLES=2 instance; inputs are scrambled after
  // the start edge to show the latched request is what counts.
  task automatic txn(input logic w, input logic [31:0] a, input logic [15:0] d,
                     input int acc_cyc, input int ack_cyc, input logic exp_err,
                     input logic [15:0] exp_rd);
    en = 1'b1; req = 1'b1; addr = a; we = w; wdata = d;
    step();
    req = 1'b0; en = 1'b0; addr = 32'h7; we = !w; wdata = 16'h0;
    for (int c = 1; c <= ack_cyc + 1; c++) begin
      chk("periph_wr", periph_wr, (c == acc_cyc) && w);
      chk("periph_rd", periph_rd, (c == acc_cyc) && !w);
      chk("ack", ack, c == ack_cyc);
      chk("busy", busy, c <= ack_cyc);
      if (c == acc_cyc) begin
        chk("periph_addr", periph_addr, a[3:0]);
        if (w) chk("periph_wdata", periph_wdata, d);
      end
      if (c == ack_cyc) chk("err", err, exp_err);
      if (c >= ack_cyc) chk("rdata", rdata, exp_rd);
      step();
    end
  endtask

  initial begin
    int first, second, busy_low, wr_seen, act;
    rst = 1'b1; en = 1'b0; req = 1'b0; addr = '0; we = 1'b0; wdata = '0;
    step();
    step();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {periph_wr, periph_rd}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_paddr", periph_addr, 0);
    chk("rst_pwdata", periph_wdata, 0);
    chk("rst_z_outs", {ack_z, err_z, busy_z, periph_wr_z, periph_rd_z}, 0);
    rst = 1'b0;
    step();

    txn(1'b1, 32'h5, 16'hBEEF, 3, 4, 1'b0, 16'h0000);
    txn(1'b0, 32'h3, 16'h0000, 3, 4, 1'b0, 16'h1234);
    txn(1'b0, 32'h10, 16'h0000, 0, 1, 1'b1, 16'h1234);
    txn(1'b1, 32'h80000003, 16'hFFFF, 0, 1, 1'b1, 16'h1234);

    // Back-to-back with req held: read 0x1 then write 0x2.
    en = 1'b1; req = 1'b1; addr = 32'h1; we = 1'b0; wdata = 16'h0;
    step();
    addr = 32'h2; we = 1'b1; wdata = 16'h5555;
    first = 0; second = 0; busy_low = 0; wr_seen = 0;
    for (int c = 1; c <= 11; c++) begin
      if (ack) begin
        if (first == 0) begin
          first = c;
          chk("b2b_rdata", rdata, 16'hA5A5);
        end else if (second == 0) begin
          second = c;
          req = 1'b0;
        end
      end
      if (first != 0 && second == 0 && !ack && !busy) busy_low++;
      if (periph_wr) begin
        wr_seen++;
        chk("b2b_paddr", periph_addr, 4'h2);
        chk("b2b_pwdata", periph_wdata, 16'h5555);
      end
      step();
    end
    chk("b2b_first_ack", first, 4);
    chk("b2b_second_ack", second, 9);
    chk("b2b_busy_gap", busy_low, 1);
    chk("b2b_wr_count", wr_seen, 1);

    en = 1'b0; req = 1'b1; addr = 32'h3; we = 1'b0;
    act = 0;
    repeat (6) begin
      step();
      act += int'(busy | ack | periph_wr | periph_rd | busy_z | ack_z);
    end
    chk("foreign_req", act, 0);
    req = 1'b0;
    step();

    // Reset while waiting: the write must vanish without strobe or ack.
    en = 1'b1; req = 1'b1; addr = 32'h6; we = 1'b1; wdata = 16'hDEAD;
    step();
    req = 1'b0; en = 1'b0;
    step();
    chk("wait_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("abort_outs", {busy, ack, err, periph_wr, periph_rd}, 0);
    chk("abort_paddr", periph_addr, 0);
    chk("abort_pwdata", periph_wdata, 0);
    chk("abort_rdata", rdata, 0);
    rst = 1'b0;
    act = 0;
    repeat (4) begin
      step();
      act += int'(periph_wr | ack);
    end
    chk("abort_quiet", act, 0);
    txn(1'b0, 32'h3, 16'h0000, 3, 4, 1'b0, 16'h1234);

    // Zero-wait instance: read 0xF.
    en = 1'b1; req = 1'b1; addr = 32'hF; we = 1'b0;
    step();
    req = 1'b0; en = 1'b0;
    chk("z_rd_c1", periph_rd_z, 1);
    chk("z_ack_c1", ack_z, 0);
    chk("z_paddr", periph_addr_z, 4'hF);
    step();
    chk("z_ack_c2", ack_z, 1);
    chk("z_err_c2", err_z, 0);
    chk("z_rd_c2", periph_rd_z, 0);
    chk("z_rdata", rdata_z, 16'hC0DE);
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_reg_target.md
# bus_reg_target

Device-side bus responder for the 16-word register peripherals (ACP, PS2, VGA windows). It accepts a translated access: this device's `device_en` bit, the physical word address, and a request strobe. It inserts a configurable number of wait states, then drives a single-cycle read or write strobe into the peripheral's register port. It returns a one-cycle `ack` with read data or an error flag. It is the responder end of the address-decoded bus, with one instance per register peripheral.

## Interface
- `ADDR_WIDTH`, 32, physical address width from the address decoder
- `DATA_WIDTH`, 16, bus word width
- `NUM_REGS`, 16, register words in this device's window; must be a power of two, at least 2
- `WAIT_CYCLES`, 2, wait states inserted before the peripheral strobe; range 0–15
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  this device's `device_en` bit
- `req`  in  1  initiator access request
- `addr`  in  ADDR_WIDTH  physical word address, relative to the window base
- `we`  in  1  1 = write, 0 = read
- `wdata`  in  DATA_WIDTH  write data
- `rdata`  out  DATA_WIDTH  read data; valid when `ack` is high and the access was a read
- `ack`  out  1  one-cycle completion pulse
- `err`  out  1  high with `ack` when the address is out of range
- `busy`  out  1  high whenever the FSM is not in IDLE
- `periph_addr`  out  clog2(NUM_REGS)  register index
- `periph_wr`  out  1  one-cycle write strobe
- `periph_rd`  out  1  one-cycle read strobe
- `periph_wdata`  out  DATA_WIDTH  write data to the peripheral
- `periph_rdata`  in  DATA_WIDTH  combinational read data from the peripheral

## Operation
- FSM states: IDLE, WAIT, ACCESS, ACK.
- **IDLE**
  - A transaction starts when `req && en` is high at a clock edge.
  - At that edge the block latches `addr`, `we` and `wdata`.
  - If `addr >= NUM_REGS` (full-width compare), go to ACK with the error flag set; no peripheral strobe is issued.
  - Otherwise, if `WAIT_CYCLES == 0`, go to ACCESS.
  - Otherwise, go to WAIT with the counter loaded to `WAIT_CYCLES-1`.
- **WAIT**
  - Counter decrements each cycle.
  - Exit to ACCESS on the cycle the counter reads 0.
- **ACCESS**
  - Exactly one cycle.
  - `periph_wr = we_q` and `periph_rd = !we_q`.
  - `periph_addr` = latched `addr` truncated to clog2(NUM_REGS) bits; `periph_wdata` = latched `wdata`.
  - For reads, `periph_rdata` is registered into `rdata` at the end of this cycle.
  - Next state is ACK.
- **ACK**
  - `ack = 1` and `err = err_q` for one cycle.
  - Next state is IDLE.
- `periph_addr` and `periph_wdata` are held at their latched values outside ACCESS; the strobes are 0 outside ACCESS.
- `rdata` holds its value until the next successful read. Writes and error completions leave it unchanged.
- The latched request is authoritative: `en`, `req`, `addr`, `we` and `wdata` changing mid-transaction have no effect.
- Back-to-back: `req && en` still high in the IDLE cycle after ACK starts a new transaction. The initiator drops `req` in the cycle it samples `ack` if no further access is intended.
- `req` high while `en` is low is ignored: the access belongs to another device.

## Timing
- Reset values: state IDLE, `ack`, `err`, `busy`, `periph_wr`, `periph_rd` all 0; `rdata`, `periph_addr`, `periph_wdata` all 0; counter 0.
- With request sampled at edge 0:
  - ACCESS is cycle `1+WAIT_CYCLES`.
  - `ack` is high in cycle `2+WAIT_CYCLES`.
  - Error completions have `ack` high in cycle 1.
- `busy` is high from cycle 1 through the ACK cycle inclusive.
- Minimum issue interval between back-to-back accesses is `3+WAIT_CYCLES` cycles.
- Reset asserted in any state (including WAIT and ACCESS):
  - Next cycle is IDLE with all outputs at reset values.
  - No strobe or `ack` is emitted for the aborted transaction.
  - A strobe already high in the reset cycle is not repeated.
- `ack` and `err` are never high outside the ACK state.
- `periph_wr` and `periph_rd` are never high simultaneously.

## Structure
- Shared package `bus_pkg` holds:
  - the state encoding (`bus_tgt_state_t`, 2 bits);
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants;
  - device ID constants: RAM 0, ROM 1, VGA 2, PS2 3, ACP 4;
  - the window size constant 16.
- One natural sub-module, `bus_wait_counter`: loadable down-counter with `load`, `load_val`, `zero` outputs, 4 bits wide. Everything else stays in `bus_reg_target`.

## Test plan
- Write, `WAIT_CYCLES=2`: `addr=0x5`, `wdata=0xBEEF`, `we=1` at edge 0 → `periph_wr=1`, `periph_addr=5`, `periph_wdata=0xBEEF` in cycle 3 only; `ack=1`, `err=0` in cycle 4; `rdata` unchanged.
- Read, `WAIT_CYCLES=2`: `addr=0x3`, peripheral drives `periph_rdata=0x1234` → `periph_rd=1` in cycle 3; `ack=1` and `rdata=0x1234` in cycle 4, `rdata` held after.
- Out of range: `addr=0x10`, then `addr=0x80000003` → `ack=1`, `err=1` in cycle 1, no peripheral strobe, `rdata` unchanged.
- Back-to-back with `req` held high: read 0x1 then write 0x2 → two `ack` pulses 5 cycles apart; `busy` low exactly one cycle between them; `en=0` with `req=1` produces no activity.
- Reset in WAIT: `rst` asserted in cycle 2 of a write → no `periph_wr` and no `ack`; all outputs 0 in the next cycle; a fresh read afterwards completes normally.
- `WAIT_CYCLES=0` build: read `addr=0xF` → `periph_rd` in cycle 1, `ack` in cycle 2.
